// File: rtl/round_robin_arbiter_8.sv
// Eight-way round-robin arbiter with registered one-hot grant,
// hold-while-requesting, forced release after MAX_HOLD cycles and idle turnaround.
module round_robin_arbiter_8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Enable,
    input  logic [7:0] Req,
    output logic [7:0] Grant,
    output logic [2:0] Grant_Index,
    output logic       Grant_Valid,
    output logic       Timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);
    localparam logic       HOLD_ON  = (MAX_HOLD != 0);

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] hold_q, hold_d;
    logic [7:0] grant_q, grant_d;
    logic [2:0] idx_q, idx_d;
    logic       valid_q, valid_d;
    logic       timeout_q, timeout_d;

    logic       win_found;
    logic [2:0] win_idx;

    // Circular search starting just after the last winner; the last
    // winner itself is checked last, so it only wins when alone.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        for (int k = 1; k <= 8; k++) begin
            logic [2:0] cand;
            cand = ptr_q + 3'(k);
            if (!win_found && Req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (Enable && win_found) begin
                    grant_d = 8'b1 << win_idx;
                    idx_d   = win_idx;
                    valid_d = 1'b1;
                    hold_d  = 8'd1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!Enable || !Req[idx_q]) begin
                    grant_d = 8'h00;
                    valid_d = 1'b0;
                    ptr_d   = idx_q;
                    hold_d  = 8'd0;
                    state_d = IDLE;
                end else if (HOLD_ON && hold_q == HOLD_LIM) begin
                    grant_d   = 8'h00;
                    valid_d   = 1'b0;
                    ptr_d     = idx_q;
                    hold_d    = 8'd0;
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else if (hold_q != 8'hFF) begin
                    hold_d = hold_q + 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= IDLE;
            ptr_q     <= 3'd7;
            hold_q    <= 8'd0;
            grant_q   <= 8'h00;
            idx_q     <= 3'd0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign Grant       = grant_q;
    assign Grant_Index = idx_q;
    assign Grant_Valid = valid_q;
    assign Timeout     = timeout_q;

endmodule

// File: tb/tb_round_robin_arbiter_8.sv
// Scoreboard bench for round_robin_arbiter_8: directed per-cycle vectors,
// checked by an independent monitor one cycle after each stimulus.
module tb_round_robin_arbiter_8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [7:0] req = 8'h00;

    logic [7:0] g4, g0;
    logic [2:0] i4, i0;
    logic       v4, v0, t4, t0;

    round_robin_arbiter_8 #(.MAX_HOLD(4)) dut4 (
        .Clock(clk), .Reset(rst), .Enable(en), .Req(req),
        .Grant(g4), .Grant_Index(i4), .Grant_Valid(v4), .Timeout(t4)
    );

    round_robin_arbiter_8 #(.MAX_HOLD(0)) dut0 (
        .Clock(clk), .Reset(rst), .Enable(en), .Req(req),
        .Grant(g0), .Grant_Index(i0), .Grant_Valid(v0), .Timeout(t0)
    );

    typedef struct {
        bit         sel;
        logic [7:0] g;
        logic [2:0] i;
        logic       v;
        logic       t;
        string      tag;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    // Drive one cycle of inputs and queue the output expected after the next edge.
    task automatic step(input logic r, input logic e, input logic [7:0] rq,
                        input bit s, input logic [7:0] eg, input logic [2:0] ei,
                        input logic ev, input logic et, input string tag);
        exp_t x;
        @(posedge clk);
        #2;
        rst = r;
        en  = e;
        req = rq;
        x.sel = s; x.g = eg; x.i = ei; x.v = ev; x.t = et; x.tag = tag;
        sbq.push_back(x);
    endtask

    initial begin
        forever begin
            exp_t       e;
            logic [7:0] ag;
            logic [2:0] ai;
            logic       av, at;
            @(posedge clk);
            #1;
            if (sbq.size() != 0) begin
                e  = sbq.pop_front();
                ag = e.sel ? g0 : g4;
                ai = e.sel ? i0 : i4;
                av = e.sel ? v0 : v4;
                at = e.sel ? t0 : t4;
                total++;
                if (ag !== e.g || ai !== e.i || av !== e.v || at !== e.t) begin
                    bad++;
                    $display("FAIL %s @%0t: got grant=%h idx=%0d valid=%b timeout=%b, want grant=%h idx=%0d valid=%b timeout=%b",
                             e.tag, $time, ag, ai, av, at, e.g, e.i, e.v, e.t);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // reset state
        step(1, 0, 8'h00, 0, 8'h00, 3'd0, 0, 0, "reset");
        step(1, 1, 8'hFF, 0, 8'h00, 3'd0, 0, 0, "reset_wins");

        // directed grant and drop
        step(0, 1, 8'h01, 0, 8'h01, 3'd0, 1, 0, "grant0");
        step(0, 1, 8'h00, 0, 8'h00, 3'd0, 0, 0, "drop0");

        // early release of requester 3 after two cycles
        step(0, 1, 8'h08, 0, 8'h08, 3'd3, 1, 0, "early_a");
        step(0, 1, 8'h08, 0, 8'h08, 3'd3, 1, 0, "early_b");
        step(0, 1, 8'h00, 0, 8'h00, 3'd3, 0, 0, "early_rel");

        // pointer skip: last winner 2, then 2 and 5 request -> 5 wins
        step(0, 1, 8'h04, 0, 8'h04, 3'd2, 1, 0, "win2");
        step(0, 1, 8'h00, 0, 8'h00, 3'd2, 0, 0, "rel2");
        step(0, 1, 8'h24, 0, 8'h20, 3'd5, 1, 0, "skip5");
        step(0, 1, 8'h04, 0, 8'h00, 3'd5, 0, 0, "rel5");
        step(0, 1, 8'h04, 0, 8'h04, 3'd2, 1, 0, "alone2");
        step(0, 1, 8'h00, 0, 8'h00, 3'd2, 0, 0, "rel2b");
        step(0, 1, 8'h04, 0, 8'h04, 3'd2, 1, 0, "again2");
        step(0, 1, 8'h00, 0, 8'h00, 3'd2, 0, 0, "rel2c");

        // enable drop mid-grant, then enable low while idle
        step(0, 1, 8'h02, 0, 8'h02, 3'd1, 1, 0, "win1");
        step(0, 0, 8'h02, 0, 8'h00, 3'd1, 0, 0, "en_off");
        step(0, 0, 8'h02, 0, 8'h00, 3'd1, 0, 0, "en_idle");

        // reset during a grant of index 6, pointer back to 7
        step(0, 1, 8'h40, 0, 8'h40, 3'd6, 1, 0, "win6");
        step(0, 1, 8'h40, 0, 8'h40, 3'd6, 1, 0, "hold6");
        step(1, 1, 8'h40, 0, 8'h00, 3'd0, 0, 0, "rst_mid");
        step(0, 1, 8'h41, 0, 8'h01, 3'd0, 1, 0, "after_rst");
        step(0, 1, 8'h00, 0, 8'h00, 3'd0, 0, 0, "rel_after");

        // forced rotation with MAX_HOLD=4 and all requesting
        step(1, 0, 8'h00, 0, 8'h00, 3'd0, 0, 0, "rot_reset");
        for (int g = 0; g < 8; g++) begin
            for (int c = 0; c < 4; c++)
                step(0, 1, 8'hFF, 0, 8'(1 << g), 3'(g), 1, 0, "rotate");
            step(0, 1, 8'hFF, 0, 8'h00, 3'(g), 0, 1, "rot_timeout");
        end
        for (int c = 0; c < 4; c++)
            step(0, 1, 8'hFF, 0, 8'h01, 3'd0, 1, 0, "rot_wrap");
        step(0, 1, 8'h00, 0, 8'h00, 3'd0, 0, 0, "rot_drop");

        // unlimited hold on the MAX_HOLD=0 instance
        step(1, 0, 8'h00, 1, 8'h00, 3'd0, 0, 0, "unl_reset");
        for (int c = 0; c < 300; c++)
            step(0, 1, 8'h80, 1, 8'h80, 3'd7, 1, 0, "unlimited");
        @(posedge clk);
        #1;
        total++;
        if (dut0.hold_q !== 8'd255) begin
            bad++;
            $display("FAIL hold_sat: got hold_count=%0d, want 255", dut0.hold_q);
        end
        step(0, 1, 8'h00, 1, 8'h00, 3'd7, 0, 0, "unl_drop");

        for (int c = 0; c < 10 && sbq.size() != 0; c++)
            @(posedge clk);
        #3;
        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending, want 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
